// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_pkg
//  Brief    : Mode encodings and reset-default configuration for clk_div_prog.
//  Revision : 1.0
// ============================================================================
package clk_div_pkg;

  localparam logic MODE_INT   = 1'b0;
  localparam logic MODE_NCO   = 1'b1;

  localparam int   DEF_DIV_W  = 8;
  localparam int   DEF_ACC_W  = 24;

  // 245 reproduces the legacy fixed sample-rate divider (period 246)
  localparam logic DEF_MODE_C = MODE_INT;
  localparam int   DEF_DIV_C  = 245;
  localparam int   DEF_INC_C  = 0;

endpackage
`default_nettype wire

// File: rtl/cfg_shadow_reg.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_shadow_reg
//  Brief    : Valid/ready capture of a new rate into a shadow register, with the
//             pending flag and the apply strobe issued at a period boundary.
//  Revision : 1.0
// ============================================================================
module cfg_shadow_reg
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic             cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic             boundary,
  output logic             cfg_ready,
  output logic             apply,
  output logic             mode_s,
  output logic [DIV_W-1:0] div_s,
  output logic [ACC_W-1:0] inc_s
);

  logic             pending_q, pending_d;
  logic             mode_s_q, mode_s_d;
  logic [DIV_W-1:0] div_s_q, div_s_d;
  logic [ACC_W-1:0] inc_s_q, inc_s_d;
  logic             capture;

  // capture needs pending=0 and apply needs pending=1, so they never coincide
  always_comb begin
    capture   = cfg_valid & ~pending_q;
    apply     = pending_q & boundary;
    pending_d = pending_q;
    mode_s_d  = mode_s_q;
    div_s_d   = div_s_q;
    inc_s_d   = inc_s_q;
    if (capture) begin
      pending_d = 1'b1;
      mode_s_d  = cfg_mode;
      div_s_d   = cfg_div;
      inc_s_d   = cfg_inc;
    end else if (apply) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pending_q <= 1'b0;
      mode_s_q  <= MODE_INT;
      div_s_q   <= '0;
      inc_s_q   <= '0;
    end else begin
      pending_q <= pending_d;
      mode_s_q  <= mode_s_d;
      div_s_q   <= div_s_d;
      inc_s_q   <= inc_s_d;
    end
  end

  assign cfg_ready = ~pending_q;
  assign mode_s    = mode_s_q;
  assign div_s     = div_s_q;
  assign inc_s     = inc_s_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog
//  Brief    : Runtime-programmable sample-tick generator (integer divider or
//             NCO phase accumulator) with glitch-free rate reload.
//  Revision : 1.0
// ============================================================================
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int               DIV_W    = DEF_DIV_W,
  parameter int               ACC_W    = DEF_ACC_W,
  parameter logic             DEF_MODE = DEF_MODE_C,
  parameter logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEF_DIV_C),
  parameter logic [ACC_W-1:0] DEF_INC  = ACC_W'(DEF_INC_C)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic             tick,
  output logic             clk_out,
  output logic             mode_active
);

  logic [DIV_W-1:0] cnt_q, cnt_d, cnt_run;
  logic [ACC_W-1:0] acc_q, acc_d, acc_run;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             mode_a_q, mode_a_d;
  logic [DIV_W-1:0] div_a_q, div_a_d;
  logic [ACC_W-1:0] inc_a_q, inc_a_d;
  logic [ACC_W:0]   nco_sum;
  logic             boundary;
  logic             apply;
  logic             mode_s;
  logic [DIV_W-1:0] div_s;
  logic [ACC_W-1:0] inc_s;

  cfg_shadow_reg #(
    .DIV_W (DIV_W),
    .ACC_W (ACC_W)
  ) u_cfg_shadow (
    .clk_in    (clk_in),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .cfg_inc   (cfg_inc),
    .boundary  (boundary),
    .cfg_ready (cfg_ready),
    .apply     (apply),
    .mode_s    (mode_s),
    .div_s     (div_s),
    .inc_s     (inc_s)
  );

  // Free-running core under the active config; the boundary tick always uses it
  always_comb begin
    nco_sum = {1'b0, acc_q} + {1'b0, inc_a_q};
    cnt_run = cnt_q;
    acc_run = acc_q;
    tick_d  = 1'b0;
    if (enable) begin
      if (mode_a_q == MODE_INT) begin
        if (cnt_q == div_a_q) begin
          cnt_run = '0;
          tick_d  = 1'b1;
        end else begin
          cnt_run = cnt_q + DIV_W'(1);
        end
      end else begin
        acc_run = nco_sum[ACC_W-1:0];
        tick_d  = nco_sum[ACC_W];
      end
    end
    clk_out_d = clk_out_q ^ tick_d;
    boundary  = tick_d | ~enable | ((mode_a_q == MODE_NCO) && (inc_a_q == '0));
  end

  // Kept separate from the core so apply (derived from boundary) forms no loop
  always_comb begin
    cnt_d    = cnt_run;
    acc_d    = acc_run;
    mode_a_d = mode_a_q;
    div_a_d  = div_a_q;
    inc_a_d  = inc_a_q;
    if (apply) begin
      mode_a_d = mode_s;
      div_a_d  = div_s;
      inc_a_d  = inc_s;
      cnt_d    = '0;
      if (mode_s != mode_a_q) begin
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
      mode_a_q  <= DEF_MODE;
      div_a_q   <= DEF_DIV;
      inc_a_q   <= DEF_INC;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      mode_a_q  <= mode_a_d;
      div_a_q   <= div_a_d;
      inc_a_q   <= inc_a_d;
    end
  end

  assign tick        = tick_q;
  assign clk_out     = clk_out_q;
  assign mode_active = mode_a_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_prog
//  Brief    : Self-checking bench for clk_div_prog: tick-time scoreboard plus
//             handshake, freeze and reset corner sequences.
//  Revision : 1.0
// ============================================================================
module tb_clk_div_prog;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        cfg_mode = 1'b0;
  logic [7:0]  cfg_div = '0;
  logic [23:0] cfg_inc = '0;
  logic        tick;
  logic        clk_out;
  logic        mode_active;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;
  int n_exp = 0;
  int exp_q[$];

  clk_div_prog dut (
    .clk_in      (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mode    (cfg_mode),
    .cfg_div     (cfg_div),
    .cfg_inc     (cfg_inc),
    .tick        (tick),
    .clk_out     (clk_out),
    .mode_active (mode_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every observed tick must match the next expected tick cycle
  always @(negedge clk) begin
    if (tick) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tick", cyc, -1);
      end else begin
        check("tick_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_tick(input int c);
    exp_q.push_back(c);
    n_exp++;
  endtask

  task automatic do_reset(input logic en_after);
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b1;
    step(); step();
    check("rst_tick", int'(tick), 0);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_mode", int'(mode_active), 0);
    exp_q.delete();
    n_exp = 0;
    cfg_valid = 1'b0;
    reset = 1'b0;
    enable = en_after;
    base = cyc;
  endtask

  // Reset, load a config while frozen, then enable; returns cycle before first enabled edge
  task automatic configure(input logic mode, input logic [23:0] val, output int start);
    do_reset(1'b0);
    cfg_valid = 1'b1; cfg_mode = mode; cfg_div = val[7:0]; cfg_inc = val;
    step();
    check("cap_ready_low", int'(cfg_ready), 0);
    cfg_valid = 1'b0;
    step();
    check("apply_ready_high", int'(cfg_ready), 1);
    check("apply_mode", int'(mode_active), int'(mode));
    enable = 1'b1;
    start = cyc;
  endtask

  task automatic finish_vec(input string name);
    enable = 1'b0;
    step();
    check({name, "_missing_ticks"}, exp_q.size(), 0);
    check({name, "_clk_out"}, int'(clk_out), n_exp % 2);
    exp_q.delete();
  endtask

  typedef struct {
    string       name;
    logic        mode;
    logic [23:0] val;
    int          win;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int start;
    longint unsigned a, b;

    vecs[0] = '{"int_div0",   1'b0, 24'd0,       20};
    vecs[1] = '{"int_div3",   1'b0, 24'd3,       40};
    vecs[2] = '{"int_div99",  1'b0, 24'd99,     250};
    vecs[3] = '{"int_div255", 1'b0, 24'd255,    600};
    vecs[4] = '{"nco_q4",     1'b1, 24'h400000,  40};
    vecs[5] = '{"nco_3of8",   1'b1, 24'h600000,  48};
    vecs[6] = '{"nco_zero",   1'b1, 24'h000000,  40};
    vecs[7] = '{"nco_max",    1'b1, 24'hFFFFFF,  30};

    // Defaults straight out of reset: legacy 246-cycle period
    do_reset(1'b1);
    expect_tick(base + 246);
    expect_tick(base + 492);
    for (int k = 0; k < 500; k++) step();
    check("def_mode", int'(mode_active), 0);
    finish_vec("defaults");

    for (int v = 0; v < 8; v++) begin
      configure(vecs[v].mode, vecs[v].val, start);
      for (int k = 1; k <= vecs[v].win; k++) begin
        if (vecs[v].mode == 1'b0) begin
          if (k % (int'(vecs[v].val[7:0]) + 1) == 0) expect_tick(start + k);
        end else begin
          a = (longint'(k) * longint'(vecs[v].val)) >> 24;
          b = (longint'(k - 1) * longint'(vecs[v].val)) >> 24;
          if (a != b) expect_tick(start + k);
        end
      end
      for (int k = 0; k < vecs[v].win; k++) step();
      finish_vec(vecs[v].name);
    end

    // Reload mid-period: old period completes, then the new one starts
    configure(1'b0, 24'd99, start);
    expect_tick(start + 100);
    expect_tick(start + 110);
    expect_tick(start + 120);
    for (int k = 0; k < 30; k++) step();
    cfg_valid = 1'b1; cfg_div = 8'd9;
    step();
    check("reload_ready_low", int'(cfg_ready), 0);
    cfg_valid = 1'b0;
    while (cyc < start + 99) step();
    check("reload_ready_still_low", int'(cfg_ready), 0);
    step();
    check("reload_ready_at_apply", int'(cfg_ready), 1);
    check("reload_tick_at_apply", int'(tick), 1);
    while (cyc < start + 125) step();
    finish_vec("reload");

    // Freeze with a pending reload applied during the freeze
    configure(1'b0, 24'd99, start);
    for (int k = 0; k < 30; k++) step();
    cfg_valid = 1'b1; cfg_div = 8'd14; enable = 1'b0;
    step();
    cfg_valid = 1'b0;
    check("freeze_ready_low", int'(cfg_ready), 0);
    step();
    check("freeze_applied", int'(cfg_ready), 1);
    while (cyc < start + 80) step();
    check("freeze_tick", int'(tick), 0);
    check("freeze_clk_out", int'(clk_out), 0);
    enable = 1'b1;
    expect_tick(start + 95);
    expect_tick(start + 110);
    while (cyc < start + 115) step();
    finish_vec("freeze");

    // Mode switch NCO -> INT through the handshake while running
    configure(1'b1, 24'h400000, start);
    expect_tick(start + 4);
    expect_tick(start + 8);
    expect_tick(start + 11);
    expect_tick(start + 14);
    for (int k = 0; k < 5; k++) step();
    cfg_valid = 1'b1; cfg_mode = 1'b0; cfg_div = 8'd2;
    step();
    cfg_valid = 1'b0;
    step(); step();
    check("switch_mode_int", int'(mode_active), 0);
    while (cyc < start + 16) step();
    finish_vec("switch");

    // Reset with a pending config discards it
    configure(1'b0, 24'd99, start);
    for (int k = 0; k < 10; k++) step();
    cfg_valid = 1'b1; cfg_div = 8'd9;
    step();
    cfg_valid = 1'b0;
    check("pend_ready_low", int'(cfg_ready), 0);
    check("pend_no_ticks", exp_q.size(), 0);
    do_reset(1'b1);
    expect_tick(base + 246);
    for (int k = 0; k < 250; k++) step();
    finish_vec("pend_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
